// File: rtl/ebi_frontend.sv
// EBI front end: strobe synchroniser, write-command FIFO and ordered read path.
// Reads wait for every earlier write to leave the FIFO before requesting.
module ebi_frontend #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 19'h7FFFF,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ebi_addr,
  input  logic [DATA_WIDTH-1:0] ebi_data_in,
  output logic [DATA_WIDTH-1:0] ebi_data_out,
  output logic                  ebi_data_oe,
  input  logic                  ebi_cs,
  input  logic                  ebi_wr,
  input  logic                  ebi_rd,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  output logic [3:0]            fifo_level,
  output logic                  overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [3:0] DEPTH_L = 4'(FIFO_DEPTH);
  localparam logic [CW-1:0] TO_LAST = CW'(RD_TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] DEAD = DATA_WIDTH'(16'hDEAD);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_REQ, S_WAIT, S_HOLD
  } state_t;

  logic [1:0] cs_q, wr_q, rd_q;
  logic cs_s, wr_s, rd_s;
  logic cs_d, wr_d, rd_d;
  logic wr_fall, rd_rise, commit;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_data;

  assign cs_s = ~cs_q[1];
  assign wr_s = ~wr_q[1];
  assign rd_s = ~rd_q[1];
  assign wr_fall = wr_d & ~wr_s & cs_d;
  assign rd_rise = rd_s & ~rd_d & cs_s;

  // Synchroniser flops idle at 1 so strobes read as inactive out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_q <= '1;
      wr_q <= '1;
      rd_q <= '1;
      cs_d <= 1'b0;
      wr_d <= 1'b0;
      rd_d <= 1'b0;
      commit <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      ebi_data_oe <= 1'b0;
    end else begin
      cs_q <= {cs_q[0], ebi_cs};
      wr_q <= {wr_q[0], ebi_wr};
      rd_q <= {rd_q[0], ebi_rd};
      cs_d <= cs_s;
      wr_d <= wr_s;
      rd_d <= rd_s;
      commit <= wr_fall;
      ebi_data_oe <= cs_s & rd_s;
      if (cs_s && wr_s) begin
        cap_addr <= ebi_addr;
        cap_data <= ebi_data_in;
      end
    end
  end

  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [3:0] level;
  logic is_status, push, pop, accept;

  assign is_status = (cap_addr == STATUS_ADDR);
  assign push = commit & ~is_status;
  assign cmd_valid = (level != 4'd0);
  assign pop = cmd_valid & cmd_ready;
  assign accept = push & ((level != DEPTH_L) | pop);
  assign cmd_addr = mem_addr[rd_ptr];
  assign cmd_data = mem_data[rd_ptr];
  assign fifo_level = level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        mem_addr[wr_ptr] <= cap_addr;
        mem_data[wr_ptr] <= cap_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)
        level <= level + 4'd1;
      else if (!accept && pop)
        level <= level - 4'd1;
      if (push && !accept)
        overflow <= 1'b1;
      else if (commit && is_status && cap_data[0])
        overflow <= 1'b0;
    end
  end

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] dout_n, status_word;

  always_comb begin
    status_word = '0;
    status_word[DATA_WIDTH-1] = overflow;
    status_word[3:0] = level;
  end

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    addr_n = rd_addr;
    dout_n = ebi_data_out;
    rd_req = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rd_rise) begin
          state_n = S_DRAIN;
          addr_n = ebi_addr;
        end
      end
      S_DRAIN: begin
        if (!rd_s) begin
          state_n = S_IDLE;
        end else if (level == 4'd0 && !commit && !wr_fall) begin
          if (rd_addr == STATUS_ADDR) begin
            state_n = S_HOLD;
            dout_n = status_word;
          end else begin
            state_n = S_REQ;
          end
        end
      end
      S_REQ: begin
        rd_req = 1'b1;
        cnt_n = CW'(1);
        state_n = rd_s ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (!rd_s) begin
          state_n = S_IDLE;
        end else if (rd_valid) begin
          state_n = S_HOLD;
          dout_n = rd_data;
        end else if (cnt == TO_LAST) begin
          state_n = S_HOLD;
          dout_n = DEAD;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (!rd_s)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      rd_addr <= '0;
      ebi_data_out <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rd_addr <= addr_n;
      ebi_data_out <= dout_n;
    end
  end

endmodule

// File: tb/tb_ebi_frontend.sv
// Bench for ebi_frontend: queue model of the command FIFO,
// sticky overflow bit and last read word, with random traffic.
module tb_ebi_frontend;

  localparam int AW = 19;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int TO = 15;
  localparam logic [AW-1:0] STAT = 19'h7FFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [AW-1:0] ebi_addr = '0;
  logic [DW-1:0] ebi_data_in = '0;
  logic [DW-1:0] ebi_data_out;
  logic ebi_data_oe;
  logic ebi_cs = 1'b1;
  logic ebi_wr = 1'b1;
  logic ebi_rd = 1'b1;
  logic cmd_valid;
  logic cmd_ready = 1'b0;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic rd_valid = 1'b0;
  logic [3:0] fifo_level;
  logic overflow;

  ebi_frontend dut (
    .clk(clk), .reset(reset),
    .ebi_addr(ebi_addr), .ebi_data_in(ebi_data_in),
    .ebi_data_out(ebi_data_out), .ebi_data_oe(ebi_data_oe),
    .ebi_cs(ebi_cs), .ebi_wr(ebi_wr), .ebi_rd(ebi_rd),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [AW+DW-1:0] mq[$];
  logic [AW+DW-1:0] plog[$];
  logic m_ovf = 1'b0;
  logic [DW-1:0] m_dout = '0;
  bit inflight = 1'b0;
  int ready_mode = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: cmd_ready = 1'b0;
      1: cmd_ready = 1'b1;
      default: cmd_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Consumer side: every accepted head must be the oldest model entry
  always @(posedge clk) begin
    if (!reset && cmd_ready && mq.size() > 0) begin
      check("pop_valid", cmd_valid, 1);
      check("pop_cmd", {cmd_addr, cmd_data}, mq[0]);
      plog.push_back(mq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!reset && !inflight) begin
      check("level", fifo_level, mq.size());
      check("cmd_valid", cmd_valid, mq.size() > 0);
      if (mq.size() > 0)
        check("head", {cmd_addr, cmd_data}, mq[0]);
      check("overflow", overflow, m_ovf);
    end
  end

  task automatic model_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (a == STAT) begin
      if (d[0]) m_ovf = 1'b0;
    end else if (mq.size() < DEPTH) begin
      mq.push_back({a, d});
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic ebi_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    ebi_addr = a;
    ebi_data_in = d;
    ebi_cs = 1'b0;
    @(posedge clk); #1;
    ebi_wr = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    ebi_wr = 1'b1;
    inflight = 1'b1;
    @(posedge clk); #1;
    ebi_cs = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    model_push(a, d);
    inflight = 1'b0;
    ebi_addr = AW'($urandom);
    ebi_data_in = DW'($urandom);
  endtask

  task automatic ebi_read(input logic [AW-1:0] a, input int dly,
                          input int release_at, input logic [DW-1:0] rdat);
    int j = -1;
    int nreq = 0;
    int it;
    int done_at = 0;
    int saved = ready_mode;
    logic [DW-1:0] prev = m_dout;
    logic [DW-1:0] exp;
    bit is_stat = (a == STAT);
    @(posedge clk); #1;
    ebi_addr = a;
    ebi_cs = 1'b0;
    ebi_rd = 1'b0;
    for (it = 0; it < 400; it++) begin
      @(posedge clk); #1;
      if (it == release_at) ready_mode = 1;
      rd_valid = 1'b0;
      if (rd_req) begin
        nreq++;
        check("rd_after_writes", mq.size(), 0);
        check("rd_addr", rd_addr, a);
        if (j < 0) j = it;
      end
      if (j >= 0 && dly > 0 && it == j + dly) begin
        rd_valid = 1'b1;
        rd_data = rdat;
      end
      if (j >= 0 && dly == 0 && it == j + TO - 1)
        check("timeout_early", ebi_data_out, prev);
      if (j >= 0 && dly == 0 && it == j + TO)
        check("timeout_exact", ebi_data_out, 16'hDEAD);
      if (is_stat && mq.size() == 0 && done_at == 0) done_at = it + 8;
      if (j >= 0 && done_at == 0) done_at = j + TO + 4;
      if (done_at != 0 && it >= done_at) break;
    end
    rd_valid = 1'b0;
    check("read_bounded", it < 400, 1);
    if (is_stat) exp = {m_ovf, 15'b0};
    else if (dly > 0 && dly < TO) exp = rdat;
    else exp = 16'hDEAD;
    check("rd_req_count", nreq, is_stat ? 0 : 1);
    check("rd_data_out", ebi_data_out, exp);
    check("rd_oe", ebi_data_oe, 1);
    m_dout = exp;
    ebi_rd = 1'b1;
    ebi_cs = 1'b1;
    ready_mode = saved;
    repeat (3) begin @(posedge clk); #1; end
    check("oe_off", ebi_data_oe, 0);
    rd_valid = 1'b1;
    rd_data = ~exp;
    @(posedge clk); #1;
    rd_valid = 1'b0;
    @(posedge clk); #1;
    check("dout_hold", ebi_data_out, exp);
    ebi_addr = AW'($urandom);
  endtask

  task automatic reset_now();
    reset = 1'b1;
    ebi_cs = 1'b1;
    ebi_wr = 1'b1;
    ebi_rd = 1'b1;
    rd_valid = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_dout = '0;
    #1;
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd", {cmd_addr, cmd_data}, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_dout", {ebi_data_oe, ebi_data_out}, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", cmd_valid, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rdv;
    int found;
    repeat (2) @(posedge clk);
    #1;
    reset_now();

    ready_mode = 1;
    repeat (2) @(posedge clk);
    ebi_write(19'h32, 16'hA5A5);
    check("t1_valid", cmd_valid, 1);
    check("t1_cmd", {cmd_addr, cmd_data}, {19'h32, 16'hA5A5});
    @(posedge clk); #1;
    check("t1_pulse", cmd_valid, 0);

    ready_mode = 0;
    repeat (2) @(posedge clk);
    plog.delete();
    for (int i = 0; i < 9; i++)
      ebi_write(AW'(32'h100 + i), DW'(32'h1000 + 17 * i));
    check("t2_level", fifo_level, 8);
    check("t2_overflow", overflow, 1);
    ready_mode = 1;
    repeat (12) @(posedge clk);
    #1;
    check("t2_count", plog.size(), 8);
    for (int i = 0; i < 8 && i < plog.size(); i++)
      check("t2_order", plog[i],
            {AW'(32'h100 + i), DW'(32'h1000 + 17 * i)});
    ebi_write(STAT, 16'h0001);
    check("t2_ovf_clear", overflow, 0);

    ready_mode = 0;
    for (int i = 0; i < 3; i++)
      ebi_write(AW'(32'h200 + i), DW'($urandom));
    ebi_read(19'h40, 3, 10, 16'h1234);
    check("t3_data", ebi_data_out, 16'h1234);

    ebi_read(19'h50, 0, 0, 16'h0);
    check("t4_dead", ebi_data_out, 16'hDEAD);
    ebi_read(19'h51, TO - 1, 0, 16'h5A5A);
    ebi_read(19'h52, TO, 0, 16'h6B6B);

    ready_mode = 0;
    for (int i = 0; i < 10; i++)
      ebi_write(AW'(32'h300 + i), DW'($urandom));
    ready_mode = 1;
    repeat (12) @(posedge clk);
    ready_mode = 0;
    ebi_write(19'h400, 16'h1111);
    ebi_write(19'h401, 16'h2222);
    check("t5_queued", fifo_level, 2);
    ebi_read(STAT, 0, 3, 16'h0);
    check("t5_status", ebi_data_out, 16'h8000);

    for (int k = 0; k < 40; k++) begin
      ready_mode = ($urandom_range(0, 2) == 0) ? 0 : 2;
      ra = AW'($urandom);
      rdv = DW'($urandom);
      if ($urandom_range(0, 9) == 0) ra = STAT;
      else if (ra == STAT) ra = '0;
      if ($urandom_range(0, 9) < 7)
        ebi_write(ra, rdv);
      else
        ebi_read(ra, $urandom_range(0, TO + 2),
                 $urandom_range(0, 5), rdv);
    end

    ready_mode = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++)
      ebi_write(AW'(32'h500 + i), DW'($urandom));
    check("t6_queued", fifo_level, 4);
    ebi_addr = 19'h60;
    ebi_cs = 1'b0;
    ebi_rd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_now();

    ready_mode = 1;
    ebi_addr = 19'h61;
    ebi_cs = 1'b0;
    ebi_rd = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(posedge clk); #1;
      if (rd_req) found = 1;
    end
    check("t6_req_seen", found, 1);
    repeat (3) @(posedge clk);
    #1;
    reset_now();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
